// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, byte-masked data memory between the
// instruction-fetch port (port 0, read-only) and the load/store port (port 1).
// Grants are combinational in the request cycle; the response (rvalid, err,
// rdata) is registered and appears on the following cycle.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH      = 100,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_p0_req,
    input  logic [ADDR_W-1:0] i_p0_addr,
    output logic              o_p0_gnt,
    output logic              o_p0_rvalid,
    output logic [31:0]       o_p0_rdata,
    output logic              o_p0_err,
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [31:0]       i_p1_wdata,
    input  logic [3:0]        i_p1_bmask,
    output logic              o_p1_gnt,
    output logic              o_p1_rvalid,
    output logic [31:0]       o_p1_rdata,
    output logic              o_p1_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata,
    output logic [15:0]       o_conflict_cnt
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    port_t             last_gnt;
    logic [ADDR_W-1:0] p0_idx;
    logic [ADDR_W-1:0] p1_idx;
    logic              p0_bad;
    logic              p1_bad;
    logic              p0_gnt;
    logic              p1_gnt;

    assign o_p0_gnt = p0_gnt;
    assign o_p1_gnt = p1_gnt;

    // Word index and range/alignment screening for both requesters
    always_comb begin
        p0_idx = {2'b00, i_p0_addr[ADDR_W-1:2]};
        p1_idx = {2'b00, i_p1_addr[ADDR_W-1:2]};
        p0_bad = (p0_idx >= ADDR_W'(DEPTH)) || (i_p0_addr[1:0] != 2'b00);
        p1_bad = (p1_idx >= ADDR_W'(DEPTH)) || (i_p1_addr[1:0] != 2'b00);
    end

    // Per-cycle grant: single requester wins outright; contention goes to
    // port 1 under fixed priority, otherwise to the port not granted last
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!i_reset) begin
            if (i_p1_req && (!i_p0_req || FIXED_PRIO || last_gnt == PORT0)) begin
                p1_gnt = 1'b1;
            end else if (i_p0_req) begin
                p0_gnt = 1'b1;
            end
        end
    end

    // Memory drive from the granted port; erroring accesses never write
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        o_mem_wren  = 1'b0;
        if (p0_gnt) begin
            o_mem_addr = p0_idx;
        end else if (p1_gnt) begin
            o_mem_addr  = p1_idx;
            o_mem_wdata = i_p1_wdata;
            o_mem_bmask = i_p1_bmask;
            o_mem_wren  = i_p1_we && !p1_bad;
        end
    end

    // Round-robin pointer tracks the most recent grant, holds when idle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_gnt <= PORT1;
        end else if (p0_gnt) begin
            last_gnt <= PORT0;
        end else if (p1_gnt) begin
            last_gnt <= PORT1;
        end
    end

    // Registered responses; rdata holds until the port's next response
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_p0_rvalid <= 1'b0;
            o_p0_err    <= 1'b0;
            o_p0_rdata  <= '0;
            o_p1_rvalid <= 1'b0;
            o_p1_err    <= 1'b0;
            o_p1_rdata  <= '0;
        end else begin
            o_p0_rvalid <= p0_gnt;
            o_p0_err    <= p0_gnt && p0_bad;
            o_p1_rvalid <= p1_gnt;
            o_p1_err    <= p1_gnt && p1_bad;
            if (p0_gnt) begin
                o_p0_rdata <= p0_bad ? '0 : i_mem_rdata;
            end
            if (p1_gnt) begin
                o_p1_rdata <= (p1_bad || i_p1_we) ? '0 : i_mem_rdata;
            end
        end
    end

    // Saturating count of cycles in which both ports request
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_conflict_cnt <= '0;
        end else if (i_p0_req && i_p1_req && o_conflict_cnt != '1) begin
            o_conflict_cnt <= o_conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked against a transaction-level reference model (winner choice, shadow
// memory, expected responses) held in the bench.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 100;

    logic        clk;
    logic        rst;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_bmask;

    logic        o_p0_gnt, o_p0_rvalid, o_p0_err;
    logic [31:0] o_p0_rdata;
    logic        o_p1_gnt, o_p1_rvalid, o_p1_err;
    logic [31:0] o_p1_rdata;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] mem_rdata;
    logic [15:0] o_conflict_cnt;

    logic        fp_gnt0, fp_rv0, fp_err0, fp_gnt1, fp_rv1, fp_err1, fp_wren;
    logic [31:0] fp_rd0, fp_rd1, fp_maddr, fp_wdata, fp_rdata;
    logic [3:0]  fp_bmask;
    logic [15:0] fp_cnt;

    // Bench memory behind the round-robin instance
    logic [31:0] mem0    [DEPTH];
    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          exp_last;
    int          exp_cnt;
    logic        e_rv0, e_err0, e_rv1, e_err1;
    logic [31:0] e_rd0, e_rd1;

    int checks;
    int errors;

    logic [70:0] comb_obs;
    logic [67:0] resp_obs;

    assign comb_obs = {o_p0_gnt, o_p1_gnt, o_mem_wren, o_mem_bmask, o_mem_addr, o_mem_wdata};
    assign resp_obs = {o_p0_rvalid, o_p0_err, o_p0_rdata, o_p1_rvalid, o_p1_err, o_p1_rdata};
    assign mem_rdata = (o_mem_addr < DEPTH) ? mem0[o_mem_addr[6:0]] : 32'hFFFF_FFFF;
    assign fp_rdata  = '0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr),
        .o_p0_gnt(o_p0_gnt), .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata), .o_p0_err(o_p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .i_p1_bmask(p1_bmask),
        .o_p1_gnt(o_p1_gnt), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata), .o_p1_err(o_p1_err),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .o_mem_wren(o_mem_wren), .i_mem_rdata(mem_rdata), .o_conflict_cnt(o_conflict_cnt)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_reset(rst),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr),
        .o_p0_gnt(fp_gnt0), .o_p0_rvalid(fp_rv0), .o_p0_rdata(fp_rd0), .o_p0_err(fp_err0),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .i_p1_bmask(p1_bmask),
        .o_p1_gnt(fp_gnt1), .o_p1_rvalid(fp_rv1), .o_p1_rdata(fp_rd1), .o_p1_err(fp_err1),
        .o_mem_addr(fp_maddr), .o_mem_wdata(fp_wdata), .o_mem_bmask(fp_bmask),
        .o_mem_wren(fp_wren), .i_mem_rdata(fp_rdata), .o_conflict_cnt(fp_cnt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // -1: nobody, 0/1: winning port, from the arbitration rules
    function automatic int winner(input bit fixed);
        if (rst) return -1;
        if (p0_req && p1_req) return fixed ? 1 : ((exp_last == 0) ? 1 : 0);
        if (p0_req) return 0;
        if (p1_req) return 1;
        return -1;
    endfunction

    function automatic logic [70:0] exp_comb();
        int          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        we;
        w  = winner(1'b0);
        a  = '0;
        d  = '0;
        m  = '0;
        we = 1'b0;
        if (w == 0) a = p0_addr / 4;
        if (w == 1) begin
            a  = p1_addr / 4;
            d  = p1_wdata;
            m  = p1_bmask;
            we = p1_we && !is_bad(p1_addr);
        end
        return {w == 0, w == 1, we, m, a, d};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom_range(0, DEPTH + 4) * 4;
        if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
        return a;
    endfunction

    task automatic model_reset();
        exp_last = 1;
        exp_cnt  = 0;
        e_rv0 = 1'b0; e_err0 = 1'b0; e_rd0 = '0;
        e_rv1 = 1'b0; e_err1 = 1'b0; e_rd1 = '0;
    endtask

    // Advance the reference model across one clock edge
    task automatic model_edge();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        w = winner(1'b0);
        if (p0_req && p1_req && exp_cnt < 65535) exp_cnt++;
        e_rv0  = (w == 0);
        e_rv1  = (w == 1);
        e_err0 = (w == 0) && is_bad(p0_addr);
        e_err1 = (w == 1) && is_bad(p1_addr);
        if (w == 0) e_rd0 = e_err0 ? '0 : ref_mem[p0_addr / 4];
        if (w == 1) begin
            e_rd1 = (e_err1 || p1_we) ? '0 : ref_mem[p1_addr / 4];
            if (p1_we && !e_err1)
                for (int b = 0; b < 4; b++)
                    if (p1_bmask[b]) ref_mem[p1_addr / 4][8*b +: 8] = p1_wdata[8*b +: 8];
        end
        if (w >= 0) exp_last = w;
    endtask

    // One clock edge: bench memory follows the DUT's write port, model follows the rules
    task automatic tick();
        logic        w_en;
        logic [31:0] w_a;
        logic [31:0] w_d;
        logic [3:0]  w_m;
        w_en = o_mem_wren;
        w_a  = o_mem_addr;
        w_d  = o_mem_wdata;
        w_m  = o_mem_bmask;
        @(posedge clk);
        model_edge();
        #1;
        if (w_en && w_a < DEPTH)
            for (int b = 0; b < 4; b++)
                if (w_m[b]) mem0[w_a[6:0]][8*b +: 8] = w_d[8*b +: 8];
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic we,
                         input logic [31:0] a1, input logic [31:0] wd, input logic [3:0] bm);
        p0_req   = r0;
        p0_addr  = a0;
        p1_req   = r1;
        p1_we    = we;
        p1_addr  = a1;
        p1_wdata = wd;
        p1_bmask = bm;
    endtask

    task automatic test_reset();
        drive(1, 32'h10, 1, 1, 32'h20, 32'h5555_5555, 4'hF);
        @(negedge clk);
        checks++;
        if ({o_p0_gnt, o_p1_gnt, o_mem_wren} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt: gnt0/gnt1/wren=%b required 000", {o_p0_gnt, o_p1_gnt, o_mem_wren});
        end
        checks++;
        if (resp_obs !== '0) begin
            errors++;
            $display("FAIL reset_resp: got %h required 0", resp_obs);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d required 0", o_conflict_cnt);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_read();
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p0_gnt, o_p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL read_gnt: gnt0/gnt1=%b required 10", {o_p0_gnt, o_p1_gnt});
        end
        checks++;
        if (o_mem_addr !== 32'd4) begin
            errors++;
            $display("FAIL read_addr: got %0d required 4", o_mem_addr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p0_rvalid, o_p0_err, o_p0_rdata} !== {2'b10, 32'hC0DE_0004}) begin
            errors++;
            $display("FAIL read_resp: rv/err/data=%b/%b/%h required 1/0/c0de0004",
                     o_p0_rvalid, o_p0_err, o_p0_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({o_p0_rvalid, o_p0_rdata} !== {1'b0, 32'hC0DE_0004}) begin
            errors++;
            $display("FAIL read_hold: rv/data=%b/%h required 0/c0de0004", o_p0_rvalid, o_p0_rdata);
        end
    endtask

    task automatic test_write_read();
        drive(0, 0, 1, 1, 32'h8, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        checks++;
        if (comb_obs !== {1'b0, 1'b1, 1'b1, 4'b0011, 32'd2, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_drive: got %h required %h", comb_obs,
                     {1'b0, 1'b1, 1'b1, 4'b0011, 32'd2, 32'hDEAD_BEEF});
        end
        tick();
        drive(0, 0, 1, 0, 32'h8, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p1_gnt, o_mem_wren} !== 2'b10) begin
            errors++;
            $display("FAIL read_nowren: gnt1/wren=%b required 10", {o_p1_gnt, o_mem_wren});
        end
        checks++;
        if ({o_p1_rvalid, o_p1_err, o_p1_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL write_resp: rv/err/data=%b/%b/%h required 1/0/0", o_p1_rvalid, o_p1_err, o_p1_rdata);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p1_rvalid, o_p1_rdata} !== {1'b1, 32'h0000_BEEF}) begin
            errors++;
            $display("FAIL readback: rv/data=%b/%h required 1/0000beef", o_p1_rvalid, o_p1_rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        drive(1, 32'h0, 1, 0, 32'h4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({o_p0_gnt, o_p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: gnt0/gnt1=%b required %b", i, {o_p0_gnt, o_p1_gnt},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (o_conflict_cnt !== 16'd4) begin
            errors++;
            $display("FAIL rr_cnt: got %0d required 4", o_conflict_cnt);
        end
        tick();
    endtask

    task automatic test_fixed_prio();
        drive(1, 32'h0, 1, 0, 32'h4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({fp_gnt0, fp_gnt1} !== 2'b01) begin
                errors++;
                $display("FAIL fp_gnt[%0d]: gnt0/gnt1=%b required 01", i, {fp_gnt0, fp_gnt1});
            end
            tick();
        end
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({fp_gnt0, fp_gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL fp_release: gnt0/gnt1=%b required 10", {fp_gnt0, fp_gnt1});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_errors();
        drive(0, 0, 1, 1, 32'h192, 32'h1234_5678, 4'hF);
        @(negedge clk);
        checks++;
        if ({o_p1_gnt, o_mem_wren, o_mem_addr} !== {2'b10, 32'd100}) begin
            errors++;
            $display("FAIL err_wr_drive: gnt1/wren/addr=%b/%b/%0d required 1/0/100",
                     o_p1_gnt, o_mem_wren, o_mem_addr);
        end
        tick();
        drive(0, 0, 1, 0, 32'h6, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p1_rvalid, o_p1_err, o_p1_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_range_p1: rv/err/data=%b/%b/%h required 1/1/0", o_p1_rvalid, o_p1_err, o_p1_rdata);
        end
        tick();
        drive(1, 32'd400, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p1_rvalid, o_p1_err, o_p1_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_misalign_p1: rv/err/data=%b/%b/%h required 1/1/0", o_p1_rvalid, o_p1_err, o_p1_rdata);
        end
        tick();
        drive(0, 0, 1, 1, 32'hC, 32'hFFFF_FFFF, 4'b0000);
        @(negedge clk);
        checks++;
        if ({o_p0_rvalid, o_p0_err, o_p0_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_range_p0: rv/err/data=%b/%b/%h required 1/1/0", o_p0_rvalid, o_p0_err, o_p0_rdata);
        end
        checks++;
        if ({o_mem_wren, o_mem_bmask} !== 5'b1_0000) begin
            errors++;
            $display("FAIL zero_mask_wr: wren/bmask=%b/%b required 1/0000", o_mem_wren, o_mem_bmask);
        end
        tick();
        drive(0, 0, 1, 0, 32'hC, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p1_rvalid, o_p1_err} !== 2'b10) begin
            errors++;
            $display("FAIL zero_mask_resp: rv/err=%b required 10", {o_p1_rvalid, o_p1_err});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (o_p1_rdata !== 32'hC0DE_0003) begin
            errors++;
            $display("FAIL zero_mask_data: got %h required c0de0003", o_p1_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] bb [3];
        logic [31:0] want;
        bb[0] = 32'h18C;
        bb[1] = 32'h14;
        bb[2] = 32'h18;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, bb[i], 0, 0);
            @(negedge clk);
            checks++;
            if (o_p1_gnt !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: got %b required 1", i, o_p1_gnt);
            end
            if (i > 0) begin
                want = 32'hC0DE_0000 | (bb[i-1] >> 2);
                checks++;
                if ({o_p1_rvalid, o_p1_err, o_p1_rdata} !== {2'b10, want}) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: rv/err/data=%b/%b/%h required 1/0/%h",
                             i - 1, o_p1_rvalid, o_p1_err, o_p1_rdata, want);
                end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p1_rvalid, o_p1_rdata} !== {1'b1, 32'hC0DE_0006}) begin
            errors++;
            $display("FAIL b2b_last: rv/data=%b/%h required 1/c0de0006", o_p1_rvalid, o_p1_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: rvalid1=%b required 0", o_p1_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        model_reset();
        drive(1, 32'h0, 1, 0, 32'h4, 0, 0);
        #1;
        checks++;
        if ({o_p0_rvalid, o_p1_rvalid, o_conflict_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: rv0/rv1/cnt=%b/%b/%0d required 0/0/0",
                     o_p0_rvalid, o_p1_rvalid, o_conflict_cnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({resp_obs, o_conflict_cnt, o_p0_gnt, o_p1_gnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_hold: resp=%h cnt=%0d gnt=%b required all 0",
                     resp_obs, o_conflict_cnt, {o_p0_gnt, o_p1_gnt});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({o_p0_gnt, o_p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_rr: gnt0/gnt1=%b required 10", {o_p0_gnt, o_p1_gnt});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({o_p0_rvalid, o_conflict_cnt} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL mid_reset_after: rv0/cnt=%b/%0d required 1/1", o_p0_rvalid, o_conflict_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        bit hold0;
        bit hold1;
        int w;
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!hold0) begin
                p0_req  = 1'($urandom_range(0, 1));
                p0_addr = rand_addr();
            end else if ($urandom_range(0, 9) == 0) begin
                p0_req = 1'b0;
            end
            if (!hold1) begin
                p1_req   = 1'($urandom_range(0, 1));
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = rand_addr();
                p1_wdata = $urandom;
                p1_bmask = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 9) == 0) begin
                p1_req = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (comb_obs !== exp_comb()) begin
                errors++;
                $display("FAIL rand_drive[%0d]: got %h required %h", i, comb_obs, exp_comb());
            end
            checks++;
            if (resp_obs !== {e_rv0, e_err0, e_rd0, e_rv1, e_err1, e_rd1}) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got %h required %h", i, resp_obs,
                         {e_rv0, e_err0, e_rd0, e_rv1, e_err1, e_rd1});
            end
            checks++;
            if (o_conflict_cnt !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d required %0d", i, o_conflict_cnt, exp_cnt);
            end
            w = winner(1'b0);
            hold0 = p0_req && (w != 0);
            hold1 = p1_req && (w != 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // Scenario sequence
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i]    = 32'hC0DE_0000 | i;
            ref_mem[i] = 32'hC0DE_0000 | i;
        end
        mem0[2]    = '0;
        ref_mem[2] = '0;
        model_reset();

        test_reset();
        test_read();
        test_write_read();
        test_round_robin();
        test_fixed_prio();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
